// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched PC, instruction and delay-slot flag,
// tags misaligned or out-of-text fetches as AdEL, and counts clean retired fetches.
module if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_instr,
  input  logic        F_BD,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_BD,
  output logic [4:0]  D_excCode,
  output logic        D_valid,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;

  // Unsigned full-width range check plus word alignment.
  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        f_fault;

  assign f_fault = fetch_fault(F_PC);

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    bd_d        = bd_q;
    exc_code_d  = exc_code_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!reset) begin
      pc_d        = '0;
      instr_d     = '0;
      bd_d        = 1'b0;
      exc_code_d  = EXC_NONE;
      valid_d     = 1'b0;
      fetch_cnt_d = '0;
    end else if (req) begin
      // Bubble carrying the handler PC so later EPC capture sees a real address.
      pc_d       = HANDLER_PC;
      instr_d    = '0;
      bd_d       = 1'b0;
      exc_code_d = EXC_NONE;
      valid_d    = 1'b0;
    end else if (stall) begin
      // Hold everything; a concurrent flush is dropped.
    end else if (flush) begin
      pc_d       = F_PC;
      instr_d    = '0;
      bd_d       = 1'b0;
      exc_code_d = EXC_NONE;
      valid_d    = 1'b0;
    end else if (f_fault) begin
      pc_d       = F_PC;
      instr_d    = '0;
      bd_d       = F_BD;
      exc_code_d = EXC_ADEL;
      valid_d    = 1'b1;
    end else begin
      pc_d        = F_PC;
      instr_d     = F_instr;
      bd_d        = F_BD;
      exc_code_d  = EXC_NONE;
      valid_d     = 1'b1;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    pc_q        <= pc_d;
    instr_q     <= instr_d;
    bd_q        <= bd_d;
    exc_code_q  <= exc_code_d;
    valid_q     <= valid_d;
    fetch_cnt_q <= fetch_cnt_d;
  end

  assign D_PC      = pc_q;
  assign D_instr   = instr_q;
  assign D_BD      = bd_q;
  assign D_excCode = exc_code_q;
  assign D_valid   = valid_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed table-driven bench for if_id_reg, plus a forced counter-wrap sequence.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, req, stall, flush, F_BD;
  logic [31:0] F_PC, F_instr;
  logic [31:0] D_PC, D_instr, fetch_cnt;
  logic        D_BD, D_valid;
  logic [4:0]  D_excCode;

  int checks = 0;
  int fails  = 0;

  if_id_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .F_PC(F_PC), .F_instr(F_instr), .F_BD(F_BD),
    .D_PC(D_PC), .D_instr(D_instr), .D_BD(D_BD), .D_excCode(D_excCode),
    .D_valid(D_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rq;
    logic        st;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_bd;
    logic [4:0]  e_exc;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vec [NVEC];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    chk("D_PC",      idx, D_PC,               v.e_pc);
    chk("D_instr",   idx, D_instr,            v.e_instr);
    chk("D_BD",      idx, {31'd0, D_BD},      {31'd0, v.e_bd});
    chk("D_excCode", idx, {27'd0, D_excCode}, {27'd0, v.e_exc});
    chk("D_valid",   idx, {31'd0, D_valid},   {31'd0, v.e_valid});
    chk("fetch_cnt", idx, fetch_cnt,          v.e_cnt);
  endtask

  initial begin
    //           rst rq st fl  F_PC          F_instr       BD   D_PC          D_instr       BD exc valid cnt
    vec[0]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0000_3000, 32'h3C01_1234, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'd0};
    vec[1]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0000_3000, 32'h3C01_1234, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'd0};
    vec[2]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3000, 32'h3C01_1234, 1'b0, 32'h0000_3000, 32'h3C01_1234, 1'b0, 5'd0, 1'b1, 32'd1};
    vec[3]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3004, 32'h8C22_0004, 1'b1, 32'h0000_3004, 32'h8C22_0004, 1'b1, 5'd0, 1'b1, 32'd2};
    vec[4]  = '{1'b1,1'b0,1'b1,1'b1, 32'h0000_3008, 32'h1111_1111, 1'b0, 32'h0000_3004, 32'h8C22_0004, 1'b1, 5'd0, 1'b1, 32'd2};
    vec[5]  = '{1'b1,1'b0,1'b1,1'b1, 32'h0000_3008, 32'h1111_1111, 1'b0, 32'h0000_3004, 32'h8C22_0004, 1'b1, 5'd0, 1'b1, 32'd2};
    vec[6]  = '{1'b1,1'b0,1'b1,1'b1, 32'h0000_3008, 32'h1111_1111, 1'b0, 32'h0000_3004, 32'h8C22_0004, 1'b1, 5'd0, 1'b1, 32'd2};
    vec[7]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3008, 32'h0043_1020, 1'b0, 32'h0000_3008, 32'h0043_1020, 1'b0, 5'd0, 1'b1, 32'd3};
    vec[8]  = '{1'b1,1'b0,1'b0,1'b1, 32'h0000_300C, 32'hAAAA_5555, 1'b1, 32'h0000_300C, 32'h0, 1'b0, 5'd0, 1'b0, 32'd3};
    vec[9]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3002, 32'h1234_5678, 1'b1, 32'h0000_3002, 32'h0, 1'b1, 5'd4, 1'b1, 32'd3};
    vec[10] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_2FFC, 32'h0000_0001, 1'b0, 32'h0000_2FFC, 32'h0, 1'b0, 5'd4, 1'b1, 32'd3};
    vec[11] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_7000, 32'h0000_0001, 1'b0, 32'h0000_7000, 32'h0, 1'b0, 5'd4, 1'b1, 32'd3};
    vec[12] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_6FFC, 32'h03E0_0008, 1'b0, 32'h0000_6FFC, 32'h03E0_0008, 1'b0, 5'd0, 1'b1, 32'd4};
    vec[13] = '{1'b1,1'b1,1'b1,1'b1, 32'h0000_3010, 32'h0000_0005, 1'b1, 32'h0000_4180, 32'h0, 1'b0, 5'd0, 1'b0, 32'd4};
    vec[14] = '{1'b1,1'b1,1'b0,1'b0, 32'h0000_3014, 32'h0000_0006, 1'b0, 32'h0000_4180, 32'h0, 1'b0, 5'd0, 1'b0, 32'd4};
    vec[15] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3010, 32'h2401_0001, 1'b1, 32'h0000_3010, 32'h2401_0001, 1'b1, 5'd0, 1'b1, 32'd5};
    vec[16] = '{1'b0,1'b1,1'b0,1'b0, 32'h0000_3014, 32'h0000_0007, 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'd0};
    vec[17] = '{1'b1,1'b0,1'b0,1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 5'd4, 1'b1, 32'd0};
    vec[18] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_0000, 32'h0000_0009, 1'b1, 32'h0000_0000, 32'h0, 1'b1, 5'd4, 1'b1, 32'd0};
    vec[19] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3001, 32'h0000_000A, 1'b0, 32'h0000_3001, 32'h0, 1'b0, 5'd4, 1'b1, 32'd0};
    vec[20] = '{1'b1,1'b0,1'b0,1'b0, 32'h0000_3018, 32'h0000_0002, 1'b0, 32'h0000_3018, 32'h0000_0002, 1'b0, 5'd0, 1'b1, 32'd1};

    reset = 1'b0; req = 1'b0; stall = 1'b0; flush = 1'b0;
    F_PC = '0; F_instr = '0; F_BD = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset = vec[i].rst_n; req = vec[i].rq; stall = vec[i].st; flush = vec[i].fl;
      F_PC = vec[i].pc; F_instr = vec[i].instr; F_BD = vec[i].bd;
      @(posedge clk);
      #1;
      check_all(i, vec[i]);
    end

    // Counter wrap: preload all-ones, then one clean load must wrap to zero.
    @(negedge clk);
    reset = 1'b1; req = 1'b0; stall = 1'b0; flush = 1'b0;
    F_PC = 32'h0000_301C; F_instr = 32'h0000_000B; F_BD = 1'b0;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    @(posedge clk);
    #1;
    chk("wrap_cnt",   NVEC, fetch_cnt, 32'd0);
    chk("wrap_pc",    NVEC, D_PC,      32'h0000_301C);
    chk("wrap_instr", NVEC, D_instr,   32'h0000_000B);

    // Stall after the wrap holds the zero count and the loaded slot.
    @(negedge clk);
    stall = 1'b1; F_PC = 32'h0000_3020; F_instr = 32'h0000_000C;
    @(posedge clk);
    #1;
    chk("wrap_hold_cnt", NVEC + 1, fetch_cnt, 32'd0);
    chk("wrap_hold_pc",  NVEC + 1, D_PC,      32'h0000_301C);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
# if_id_reg

Pipeline register between the fetch stage (PC plus instruction memory) and decode. Each cycle it captures the fetched PC and instruction word along with the branch-delay-slot flag. It also performs the fetch-side address check and tags AdEL exceptions. It supports stall (hold), flush (insert bubble) and exception-request (bubble carrying the handler PC). A retired-fetch counter is provided for the CP0/performance path.

## Interface
- No parameters. Fixed constants: text range 32'h0000_3000–32'h0000_6FFC; handler PC 32'h0000_4180; AdEL code 5'd4.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- req  input  1  exception/interrupt request from CP0; highest priority after reset.
- stall  input  1  hazard-unit stall; hold all registers.
- flush  input  1  squash the incoming fetch (bubble insertion).
- F_PC  input  32  fetch-stage PC.
- F_instr  input  32  instruction word read at F_PC.
- F_BD  input  1  fetched instruction is in a branch delay slot.
- D_PC  output  32  registered PC for decode.
- D_instr  output  32  registered instruction; 0 (nop) for any bubble or faulting fetch.
- D_BD  output  1  registered delay-slot flag.
- D_excCode  output  5  0 = none, 4 = AdEL.
- D_valid  output  1  1 = the slot holds a real fetch (including a faulting one), 0 = bubble.
- fetch_cnt  output  32  count of loaded, non-faulting fetches.

## Operation
- Fetch fault (combinational on F side): F_PC[1:0]!=0, or F_PC<32'h3000, or F_PC>32'h6FFC. This is an unsigned compare on the full 32 bits.
- Action per rising edge, evaluated in strict priority order:
  - reset==0: D_PC=0, D_instr=0, D_BD=0, D_excCode=0, D_valid=0, fetch_cnt=0.
  - req==1: D_PC=32'h4180, D_instr=0, D_BD=0, D_excCode=0, D_valid=0. This overrides stall and flush. fetch_cnt is held.
  - stall==1: all outputs and fetch_cnt are held. A flush asserted together with stall is ignored.
  - flush==1: D_PC=F_PC, D_instr=0, D_BD=0, D_excCode=0, D_valid=0. fetch_cnt is held.
  - Otherwise (load), with the fetch fault set:
    - D_PC=F_PC, D_instr=0, D_BD=F_BD, D_excCode=4, D_valid=1.
    - fetch_cnt is held.
  - Otherwise (load), with no fetch fault:
    - D_PC=F_PC, D_instr=F_instr, D_BD=F_BD, D_excCode=0, D_valid=1.
    - fetch_cnt increments by 1.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0 with no flag.
- Bubbles keep D_PC meaningful so that CP0 EPC capture in later stages sees a valid PC. For a bubble, the EPC is taken from D_PC, and D_BD=0.

## Timing
- Latency is one cycle: inputs are sampled at an edge and visible on the D_* outputs immediately after it.
- All outputs come directly from flops. There is no combinational input-to-output path.
- The fault decode is the only combinational logic. It must settle within the F_PC-to-flop path in the same cycle.
- A stall lasting N cycles holds the D_* outputs for exactly N edges. The first edge with stall==0 loads the current F_* inputs. The held instruction is not re-issued beyond the stall.
- reset deasserted (1) at edge k: normal action applies from edge k onward. A reset mid-stream discards the held slot with no residue.
- req and reset both active: reset wins.
- req asserted for consecutive cycles: the output repeats the handler-PC bubble each cycle.

## Test plan
- Reset then load: hold reset=0 for 2 edges. Then reset=1 with F_PC=32'h3000 and F_instr=32'h3C01_1234. Required after the next edge: D_PC=3000, D_instr=3C011234, D_valid=1, D_excCode=0, fetch_cnt=1.
- Stall hold, with flush masked: load PC 3004, then stall=1 and flush=1 for 3 edges while F_PC changes to 3008. Required: D_PC=3004 and the instruction are unchanged, and fetch_cnt is unchanged. On the edge after stall=0 (flush=0), D_PC=3008.
- Flush bubble: with F_PC=300C and flush=1, the next edge gives D_PC=300C, D_instr=0, D_valid=0, D_BD=0, and fetch_cnt is unchanged.
- AdEL cases:
  - F_PC=32'h3002 gives D_excCode=4, D_instr=0, D_valid=1.
  - F_PC=32'h2FFC and F_PC=32'h7000 each give D_excCode=4.
  - F_PC=32'h6FFC gives D_excCode=0.
  - fetch_cnt increments only for the 6FFC fetch.
- Request priority: raise req, stall and flush together with F_PC=3010 and F_BD=1. Required: D_PC=4180, D_instr=0, D_BD=0, D_valid=0. Asserting reset=0 together with req yields all zeros instead.
- Counter wrap: preload fetch_cnt to 32'hFFFF_FFFF by forcing, then do one clean load. Required: fetch_cnt=0.
